// File: rtl/generic_bus_mem_responder_pkg.sv
// Shared types and constants for the generic bus memory responder.
// Holds the responder FSM encoding, the captured-request record and the byte-lane helper.
package generic_bus_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic [31:0] BAD_DATA_DEFAULT = 32'hBAD1_BAD1;
    localparam int unsigned WORD_BYTES       = 4;

    // Everything about a request that must survive the wait states.
    typedef struct packed {
        logic                  write;
        logic                  in_range;
        logic [WORD_BYTES-1:0] byte_en;
        logic [31:0]           wdata;
    } req_t;

    function automatic logic [31:0] lane_mask(input logic [WORD_BYTES-1:0] byte_en);
        logic [31:0] mask;
        for (int i = 0; i < WORD_BYTES; i++) begin
            mask[8*i +: 8] = {8{byte_en[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/generic_bus_mem_responder_if.sv
// Generic request/response bus between a cache-side initiator and a memory responder.
// busy stays high until a single low cycle marks completion of the captured request.
interface generic_bus_if;

    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output addr, ren, wen, wdata, byte_en,
        input  rdata, busy
    );

    modport responder (
        input  addr, ren, wen, wdata, byte_en,
        output rdata, busy
    );

endinterface

// File: rtl/generic_bus_mem_responder_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register is reset; the storage array itself is not.
module mem_responder_array
    import generic_bus_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] byte_en,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] wmask;

    assign wmask = lane_mask(byte_en);

    // NOTE: RAM contents carry no reset so the array maps onto block RAM;
    // only the control-visible read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/generic_bus_mem_responder.sv
// Memory-side responder for generic_bus_if: captures a request, waits LATENCY cycles,
// then completes with one busy-low cycle, backed by a byte-enabled word RAM.
module generic_bus_mem_responder
    import generic_bus_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BAD_DATA    = BAD_DATA_DEFAULT
) (
    input  logic             CLK,
    input  logic             nRST,
    generic_bus_if.responder bus_if
);

    localparam int unsigned     IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned     CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    resp_state_t      state;
    resp_state_t      state_d;
    logic [CNT_W-1:0] cnt;
    req_t             req_q;
    logic [IDX_W-1:0] idx_q;
    logic             bad_q;

    logic             req_live;
    logic             capture;
    logic [31:0]      offset;
    logic             bus_in_range;
    logic [IDX_W-1:0] bus_idx;
    req_t             bus_req;
    req_t             cur_req;
    logic             rd_launch;
    logic             ram_rd_en;
    logic             ram_wr_en;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_rdata;
    logic             unused_addr_lsbs;

    // Word index relative to BASE_ADDR; addresses below the base wrap to a large
    // offset and so fall out of range together with those above the top.
    assign offset           = bus_if.addr - BASE_ADDR;
    assign bus_in_range     = (offset >> (IDX_W + 2)) == 32'd0;
    assign bus_idx          = offset[IDX_W+1:2];
    assign unused_addr_lsbs = ^offset[1:0];

    assign req_live = bus_if.ren | bus_if.wen;
    assign capture  = (state == IDLE) && req_live;

    assign bus_req = '{
        write:    bus_if.wen,
        in_range: bus_in_range,
        byte_en:  bus_if.byte_en,
        wdata:    bus_if.wdata
    };

    // With LATENCY=0 the read is launched on the capture edge itself, so the
    // live bus request stands in for the not-yet-captured one.
    assign cur_req = (state == IDLE) ? bus_req : req_q;
    assign ram_idx = (state == IDLE) ? bus_idx : idx_q;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state;
        case (state)
            IDLE: begin
                if (req_live) begin
                    if (LATENCY == 0) state_d = RESP;
                    else              state_d = WAIT;
                end
            end
            WAIT: begin
                if (!req_live)        state_d = IDLE;
                else if (cnt == CNT_ONE) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_launch = (state_d == RESP) && !cur_req.write;
    assign ram_rd_en = rd_launch && cur_req.in_range;
    assign ram_wr_en = (state == RESP) && req_q.write && req_q.in_range;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
            idx_q <= '0;
            bad_q <= 1'b0;
        end else begin
            state <= state_d;
            if (capture) begin
                req_q <= bus_req;
                idx_q <= bus_idx;
                cnt   <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_ONE;
            end
            if (rd_launch) begin
                bad_q <= ~cur_req.in_range;
            end
        end
    end

    mem_responder_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (CLK),
        .rst_n   (nRST),
        .rd_en   (ram_rd_en),
        .wr_en   (ram_wr_en),
        .idx     (ram_idx),
        .wdata   (req_q.wdata),
        .byte_en (req_q.byte_en),
        .rdata   (ram_rdata)
    );

    assign bus_if.busy  = (state != RESP);
    assign bus_if.rdata = bad_q ? BAD_DATA : ram_rdata;

endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// Directed bench for generic_bus_mem_responder: a LATENCY=2 and a LATENCY=0 instance,
// read expectations queued at issue and compared at the busy-low cycle.
module tb_generic_bus_mem_responder;

    localparam logic [31:0] BAD = 32'hBAD1_BAD1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model_mem [0:1][0:1023];
    logic [31:0] last_rdata [0:1];
    int          lat [0:1];

    always #5 clk = ~clk;

    generic_bus_if bus_a ();
    generic_bus_if bus_b ();

    generic_bus_mem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .LATENCY     (2),
        .BAD_DATA    (BAD)
    ) dut_a (
        .CLK    (clk),
        .nRST   (rst_n),
        .bus_if (bus_a)
    );

    generic_bus_mem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .LATENCY     (0),
        .BAD_DATA    (BAD)
    ) dut_b (
        .CLK    (clk),
        .nRST   (rst_n),
        .bus_if (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? bus_b.busy : bus_a.busy;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus_b.rdata : bus_a.rdata;
    endfunction

    task automatic drive(input bit sel, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (sel) begin
            bus_b.ren = r; bus_b.wen = w; bus_b.addr = a; bus_b.wdata = d; bus_b.byte_en = be;
        end else begin
            bus_a.ren = r; bus_a.wen = w; bus_a.addr = a; bus_a.wdata = d; bus_a.byte_en = be;
        end
    endtask

    function automatic logic [31:0] model_read(input bit sel, input logic [31:0] a);
        if (a >= 32'd4096) return BAD;
        return model_mem[sel][a[11:2]];
    endfunction

    task automatic model_write(input bit sel, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be);
        logic [31:0] word;
        if (a < 32'd4096) begin
            word = model_mem[sel][a[11:2]];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) word[8*i +: 8] = d[8*i +: 8];
            end
            model_mem[sel][a[11:2]] = word;
        end
    endtask

    // Counts negedges from the one after the capture edge until busy is seen low.
    task automatic wait_done(input bit sel, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = -1;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                @(negedge clk);
                if (get_busy(sel) == 1'b0) begin
                    seen   = 1'b1;
                    cycles = i;
                end
            end
        end
    endtask

    task automatic check_read_result(input bit sel, input string tag);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty queue expected=entry", tag);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_rdata"}, get_rdata(sel), exp);
            last_rdata[sel] = exp;
        end
    endtask

    task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input string tag);
        int cyc;
        @(negedge clk);
        drive(sel, !w, w, a, d, be);
        if (!w) exp_q.push_back(model_read(sel, a));
        wait_done(sel, cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(lat[sel] + 1));
        if (w) begin
            check({tag, "_hold"}, get_rdata(sel), last_rdata[sel]);
            model_write(sel, a, d, be);
        end else begin
            check_read_result(sel, tag);
        end
        drive(sel, 1'b0, 1'b0, a, d, be);
        @(negedge clk);
        check({tag, "_one_cycle"}, 32'(get_busy(sel)), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int cyc;
        int lows;

        lat[0] = 2;
        lat[1] = 0;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy_a", 32'(bus_a.busy), 32'd1);
        check("reset_rdata_a", bus_a.rdata, 32'd0);
        check("reset_busy_b", 32'(bus_b.busy), 32'd1);
        check("reset_rdata_b", bus_b.rdata, 32'd0);

        // Write then read back the same word.
        txn(1'b0, 1'b1, 32'h0, 32'hBEEF_0000, 4'hF, "wr0");
        txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, "rd0");

        // Asynchronous reset while waiting: outputs clear at once, no completion follows.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        check("rst_wait_busy_pre", 32'(bus_a.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_busy", 32'(bus_a.busy), 32'd1);
        check("rst_async_rdata", bus_a.rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        last_rdata[0] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_a.busy == 1'b0) lows++;
        end
        check("rst_no_completion", 32'(lows), 32'd0);
        check("rst_rdata_after", bus_a.rdata, 32'd0);

        // Byte lanes: only lanes 0 and 2 take the new data.
        txn(1'b0, 1'b1, 32'h4, 32'h1122_3344, 4'hF, "pre4");
        txn(1'b0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, "lane4");
        txn(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, "rd4");
        check("lane4_value", last_rdata[0], 32'h11BB_33DD);

        // Four-word fill with ren held and addr stepped at each completion.
        txn(1'b0, 1'b1, 32'h8, 32'hCAFE_0008, 4'hF, "pre8");
        txn(1'b0, 1'b1, 32'hC, 32'hF00D_000C, 4'hF, "preC");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(model_read(1'b0, 32'(k * 4)));
            wait_done(1'b0, cyc);
            check("fill_lat", 32'(cyc), (k == 0) ? 32'd3 : 32'd4);
            check_read_result(1'b0, "fill");
            if (k < 3) drive(1'b0, 1'b1, 1'b0, 32'((k + 1) * 4), 32'h0, 4'h0);
            else       drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        @(negedge clk);
        check("fill_end_busy", 32'(bus_a.busy), 32'd1);

        // Out-of-range read completes normally with the marker value.
        txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, "oor_rd");
        // Out-of-range write is dropped and does not alias onto word 0.
        txn(1'b0, 1'b1, 32'h1000, 32'hDEAD_DEAD, 4'hF, "oor_wr");
        txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, "rd0_after_oor");

        // Aborted write: request withdrawn during WAIT leaves the word untouched.
        txn(1'b0, 1'b1, 32'h20, 32'h5A5A_5A5A, 4'hF, "pre20");
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h0BAD_0BAD, 4'hF);
        @(negedge clk);
        check("abort_busy_wait", 32'(bus_a.busy), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h20, 32'h0BAD_0BAD, 4'hF);
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_a.busy == 1'b0) lows++;
        end
        check("abort_no_completion", 32'(lows), 32'd0);
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, "rd20");

        // Zero-latency build: completion in the cycle right after capture.
        txn(1'b1, 1'b1, 32'h8, 32'h1234_5678, 4'hF, "b_wr8");
        txn(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, "b_rd8");
        txn(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, "b_oor");

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/generic_bus_mem_responder.md
Name: generic_bus_mem_responder

Overview:
Synthesizable memory-side responder for generic_bus_if. It is the slave end that services requests from an initiator such as l2_cache's mem_gen_bus_if.
It is backed by a word-addressed RAM with byte-enable writes. A fixed, parameterizable wait-state count models memory-controller latency.
It replaces hand-driven busy/rdata stimulus in cache benches and serves as an on-chip scratch memory in FPGA builds.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the backing RAM (power of two).
BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be aligned to DEPTH_WORDS*4.
LATENCY, 2, wait cycles between request capture and the completion cycle (0 allowed).
BAD_DATA, 32'hBAD1_BAD1, rdata returned for out-of-range reads.

Ports:
CLK  input  1  clock, rising edge.
nRST  input  1  asynchronous active-low reset.
bus_if.addr  input  32  byte address; bits [1:0] are ignored.
bus_if.ren  input  1  read request.
bus_if.wen  input  1  write request.
bus_if.wdata  input  32  write data.
bus_if.byte_en  input  4  byte-lane enables for writes.
bus_if.rdata  output  32  read data, valid only while busy=0 on a read.
bus_if.busy  output  1  active-high. Low for exactly one cycle marks completion.
(The bus_if signals are bound through the generic_bus_if responder modport.)

Behaviour:
- Reset, asynchronous: state=IDLE, busy=1, rdata=0, counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP. busy=1 in IDLE and WAIT; busy=0 only in RESP.
- IDLE, on a rising edge with ren|wen=1:
  - Capture addr, wdata, byte_en and the operation.
  - If wen=1, the operation is a write; wen has priority when ren and wen are both asserted.
  - Load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT:
  - Counter decrements each cycle; at counter==1 the next state is RESP.
  - If ren and wen both drop to 0 during WAIT, the request is aborted: return to IDLE, no RAM write, busy stays 1.
  - Changes to addr/wdata during WAIT are ignored; the captured values are used.
- RESP (exactly one cycle):
  - busy=0.
  - Read: rdata = RAM[word index], registered so it is stable for the whole RESP cycle.
  - Write: enabled byte lanes are committed at the rising edge that leaves RESP. rdata holds its previous value.
  - Next state is always IDLE.
- Latency: from the capture edge, busy is low during cycle LATENCY+1. The initiator sees LATENCY+1 busy-high cycles after assertion, counting the assertion cycle.
- Back-to-back requests: a request still asserted in the IDLE cycle after RESP is captured as a new transaction. There is one idle cycle minimum between completions. This matches multi-word cache fills that hold ren and step addr.
- Address decode: word index = (addr-BASE_ADDR)>>2.
  - A read outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) returns BAD_DATA.
  - A write outside that range is dropped.
  - Both still complete normally, so the initiator never hangs.
- byte_en=4'b0000 on a write completes with no RAM change.
- Read-after-write to the same word in consecutive transactions returns the new data, because the commit precedes the next capture.
- Counter width: $clog2(LATENCY+1), minimum 1 bit.

Decomposition:
- Package generic_bus_mem_pkg holds:
  - the state enum resp_state_t {IDLE, WAIT, RESP};
  - the BAD_DATA default;
  - the WORD_BYTES=4 constant.
- One sub-module, mem_responder_array:
  - single-port DEPTH_WORDS x 32 RAM;
  - 4-lane byte-enable write;
  - registered read.
- The FSM, counter and address decode stay in the top module.

Test Plan:
1. Reset mid-WAIT. With LATENCY=2, assert ren addr=0x10, then pull nRST low in the WAIT state -> busy=1 and rdata=0 immediately (asynchronous). After release, the state is IDLE and no completion occurs.
2. Write then read.
   - Write addr=0x0, wdata=0xBEEF0000, byte_en=0xF -> busy low exactly 3 cycles after the capture edge.
   - Then read addr=0x0 -> rdata=0xBEEF0000 in the busy-low cycle.
3. Byte lanes. Preload word 0x4=0x11223344, then write wdata=0xAABBCCDD with byte_en=4'b0101 -> a subsequent read returns 0x11BB33DD.
4. Four-word fill. Hold ren=1 and step addr 0x0,0x4,0x8,0xC after each busy-low cycle -> four completions carrying the preloaded words in order, with one IDLE cycle between each.
5. Out-of-range and abort.
   - Read addr=0x1000 (DEPTH_WORDS=1024) -> rdata=0xBAD1BAD1 with a normal completion.
   - Write addr=0x20, then drop wen during WAIT -> no completion, and word 0x20 is unchanged.
6. LATENCY=0 build. Read addr=0x8 -> busy low in the cycle immediately after the capture edge.
